instr_fetcher: RTL

- Fetch controller servicing the instruction queue's fetch requests.
- Accepts one PC at a time from the queue and returns the 32-bit instruction with a one-cycle finish pulse.
- Looks the PC up in a direct-mapped instruction cache; on a miss, reads 4 bytes over the byte-wide memory port and fills the cache line.
- Sits between the instruction queue and the memory arbiter.

---
 rtl/instr_fetcher.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/instr_fetcher.sv
// Instruction fetch controller: a direct-mapped I-cache answers hits in one cycle.
// A miss refills the line with four byte reads over the memory arbiter port.
module instr_fetcher #(
    parameter int IndexBits   = 6,
    parameter int PcLength    = 31,
    parameter int InstrLength = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 is_exception_from_rob,
    input  logic                 is_empty_from_iq,
    input  logic [PcLength:0]    pc_from_iq,
    output logic                 is_stall_to_iq,
    output logic                 is_finish_to_iq,
    output logic [InstrLength:0] instr_to_iq,
    output logic                 is_req_to_mem,
    output logic [PcLength:0]    addr_to_mem,
    input  logic                 is_grant_from_mem,
    input  logic [7:0]           byte_from_mem
);
    localparam int Lines = 1 << IndexBits;
    localparam int TagW  = PcLength - IndexBits - 1;

    typedef enum logic {IDLE, MISS} state_t;

    state_t               state_q, state_d;
    logic [2:0]           k_q, k_d;
    logic [1:0]           r_q, r_d;
    logic                 pend_q, pend_d;
    logic                 stall_d, finish_d;
    logic [InstrLength:0] instr_d;
    logic [PcLength:0]    pc_q;
    logic [23:0]          asm_q;
    logic [Lines-1:0]     valid_q;
    logic [TagW-1:0]      tag_q  [Lines];
    logic [InstrLength:0] data_q [Lines];
    logic [IndexBits-1:0] idx_in, idx_fill;
    logic [TagW-1:0]      tag_in;
    logic                 hit, accept, complete, fill_we;
    logic [InstrLength:0] fill_word;

    always_comb begin
        idx_in        = pc_from_iq[IndexBits+1:2];
        tag_in        = pc_from_iq[PcLength:IndexBits+2];
        idx_fill      = pc_q[IndexBits+1:2];
        hit           = valid_q[idx_in] && (tag_q[idx_in] == tag_in);
        accept        = (state_q == IDLE) && !is_empty_from_iq && !is_stall_to_iq
                        && !is_exception_from_rob;
        complete      = (state_q == MISS) && pend_q && (r_q == 2'd3);
        fill_word     = {byte_from_mem, asm_q};
        is_req_to_mem = (state_q == MISS) && (k_q < 3'd4);
        addr_to_mem   = is_req_to_mem ? pc_q + {{(PcLength-2){1'b0}}, k_q} : '0;

        state_d  = state_q;
        k_d      = k_q;
        r_d      = r_q;
        pend_d   = 1'b0;
        stall_d  = is_stall_to_iq;
        finish_d = 1'b0;
        instr_d  = instr_to_iq;
        fill_we  = 1'b0;

        // Flush wins over everything; dropping pend_q discards a byte still in flight.
        if (is_exception_from_rob) begin
            state_d = IDLE;
            k_d     = '0;
            r_d     = '0;
            stall_d = 1'b0;
        end else if (state_q == MISS) begin
            if (is_req_to_mem && is_grant_from_mem) begin
                k_d    = k_q + 3'd1;
                pend_d = 1'b1;
            end
            if (pend_q) begin
                r_d = r_q + 2'd1;
            end
            if (complete) begin
                state_d  = IDLE;
                k_d      = '0;
                r_d      = '0;
                stall_d  = 1'b0;
                finish_d = 1'b1;
                instr_d  = fill_word;
                fill_we  = 1'b1;
            end
        end else if (accept) begin
            if (hit) begin
                finish_d = 1'b1;
                instr_d  = data_q[idx_in];
            end else begin
                state_d = MISS;
                k_d     = '0;
                r_d     = '0;
                stall_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            k_q             <= '0;
            r_q             <= '0;
            pend_q          <= 1'b0;
            is_stall_to_iq  <= 1'b0;
            is_finish_to_iq <= 1'b0;
            instr_to_iq     <= '0;
            valid_q         <= '0;
        end else begin
            state_q         <= state_d;
            k_q             <= k_d;
            r_q             <= r_d;
            pend_q          <= pend_d;
            is_stall_to_iq  <= stall_d;
            is_finish_to_iq <= finish_d;
            instr_to_iq     <= instr_d;
            if (fill_we) begin
                valid_q[idx_fill] <= 1'b1;
            end
        end
    end

    // Datapath storage: the valid bits alone decide whether these contents are live.
    always_ff @(posedge clk) begin
        if (accept && !hit) begin
            pc_q <= pc_from_iq;
        end
        if (pend_q) begin
            case (r_q)
                2'd0:    asm_q[7:0]   <= byte_from_mem;
                2'd1:    asm_q[15:8]  <= byte_from_mem;
                2'd2:    asm_q[23:16] <= byte_from_mem;
                default: ;
            endcase
        end
        if (fill_we) begin
            tag_q[idx_fill]  <= pc_q[PcLength:IndexBits+2];
            data_q[idx_fill] <= fill_word;
        end
    end
endmodule
